// File: rtl/apb_mem_slave_if.sv
// APB-facing bus plus the strobe-less memory port of apb_mem_slave.
// The slave modport is the bridge side; master drives APB and models the memory.
interface apb_mem_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256
) ();
    localparam int unsigned STRB_SIZE = DATA_WIDTH / 8;
    localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic                  sel;
    logic                  enable;
    logic                  write;
    logic [STRB_SIZE-1:0]  strobe;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic                  slverr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  wr;
    logic [IDX_W-1:0]      address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport slave (
        input  sel, enable, write, strobe, addr, wdata, data_out,
        output ready, slverr, rdata, wr, address, data_in
    );

    modport master (
        output sel, enable, write, strobe, addr, wdata, data_out,
        input  ready, slverr, rdata, wr, address, data_in
    );
endinterface

// File: rtl/apb_mem_slave.sv
// APB slave for a strobe-less word memory: programmable wait states,
// read-modify-write for partial-strobe writes, PSLVERR on bad addresses.
module apb_mem_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned STRB_SIZE   = DATA_WIDTH / 8,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    apb_mem_slave_if.slave io_apb
);
    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_FETCH,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  r_write;
    logic                  r_err;
    logic [STRB_SIZE-1:0]  r_strb;
    logic [WIDX_W-1:0]     r_widx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_setup;
    logic                  w_capture;
    logic                  w_err;
    logic                  w_wr;
    logic                  w_addr_vld;
    logic                  w_rdata_ld;
    logic [DATA_WIDTH-1:0] w_data_in;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_setup   = io_apb.sel && !io_apb.enable;
    assign w_capture = (r_state == S_IDLE) && w_setup;
    assign w_err     = (io_apb.addr[1:0] != 2'b00) ||
                       (io_apb.addr[ADDR_WIDTH-1:2] >= WIDX_W'(MEM_DEPTH));

    // Byte merge of captured write data over the word fetched from memory.
    always_comb begin
        w_merged = io_apb.data_out;
        for (int b = 0; b < int'(STRB_SIZE); b++) begin
            if (r_strb[b]) begin
                w_merged[b*8 +: 8] = r_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state plus the combinational memory-port strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr        = 1'b0;
        w_data_in   = '0;
        w_addr_vld  = 1'b0;
        w_rdata_ld  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_setup) begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = CNT_W'(WAIT_STATES);
                end
            end
            S_ACCESS: begin
                w_addr_vld = 1'b1;
                if (!io_apb.sel) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (r_err) begin
                    w_state_nxt = S_RESP;
                end else if (r_write && (&r_strb)) begin
                    w_wr        = 1'b1;
                    w_data_in   = r_wdata;
                    w_state_nxt = S_RESP;
                end else if (r_write && (r_strb == '0)) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_addr_vld = 1'b1;
                if (!io_apb.sel) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    if (r_write) begin
                        w_wr      = 1'b1;
                        w_data_in = w_merged;
                    end else begin
                        w_rdata_ld = 1'b1;
                    end
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Transfer attributes are sampled only when a setup phase is seen in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_strb  <= '0;
            r_widx  <= '0;
            r_wdata <= '0;
        end else if (w_capture) begin
            r_write <= io_apb.write;
            r_err   <= w_err;
            r_strb  <= io_apb.strobe;
            r_widx  <= io_apb.addr[ADDR_WIDTH-1:2];
            r_wdata <= io_apb.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_rdata_ld) begin
            r_rdata <= io_apb.data_out;
        end
    end

    assign io_apb.ready   = (r_state == S_RESP);
    assign io_apb.slverr  = (r_state == S_RESP) && r_err;
    // An errored read shows zero for its response only; the last good read is kept.
    assign io_apb.rdata   = ((r_state == S_RESP) && r_err && !r_write) ? '0 : r_rdata;
    assign io_apb.wr      = w_wr;
    assign io_apb.address = w_addr_vld ? r_widx[IDX_W-1:0] : '0;
    assign io_apb.data_in = w_data_in;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (0, 1 and 3 wait states), each with
// its own memory, checked against a word-array reference model.
module tb_apb_mem_slave;
    localparam int unsigned NI    = 3;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned IW    = $clog2(DEPTH);

    logic clk;
    logic rst_n;
    logic mem_init;

    logic          t_sel      [NI];
    logic          t_enable   [NI];
    logic          t_write    [NI];
    logic [SW-1:0] t_strobe   [NI];
    logic [AW-1:0] t_addr     [NI];
    logic [DW-1:0] t_wdata    [NI];
    logic          t_ready    [NI];
    logic          t_slverr   [NI];
    logic [DW-1:0] t_rdata    [NI];
    logic          t_wr       [NI];
    logic [IW-1:0] t_address  [NI];
    logic [DW-1:0] t_data_in  [NI];
    logic [DW-1:0] t_data_out [NI];

    logic [DW-1:0] mem     [NI][DEPTH];
    logic [DW-1:0] ref_mem [NI][DEPTH];
    logic [DW-1:0] exp_hold[NI];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        apb_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) bus ();
        assign bus.sel      = t_sel[g];
        assign bus.enable   = t_enable[g];
        assign bus.write    = t_write[g];
        assign bus.strobe   = t_strobe[g];
        assign bus.addr     = t_addr[g];
        assign bus.wdata    = t_wdata[g];
        assign bus.data_out = t_data_out[g];
        assign t_ready[g]   = bus.ready;
        assign t_slverr[g]  = bus.slverr;
        assign t_rdata[g]   = bus.rdata;
        assign t_wr[g]      = bus.wr;
        assign t_address[g] = bus.address;
        assign t_data_in[g] = bus.data_in;

        apb_mem_slave #(
            .ADDR_WIDTH (AW),
            .DATA_WIDTH (DW),
            .STRB_SIZE  (SW),
            .MEM_DEPTH  (DEPTH),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .io_apb(bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int g, input int i);
        return 32'h5A00_0000 | (32'(g) << 16) | 32'(i * 7);
    endfunction

    function automatic int ws(input int k);
        case (k)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    // Synchronous word memory: read data appears the cycle after the address.
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (mem_init) begin
                for (int i = 0; i < DEPTH; i++) mem[g][i] <= init_word(g, i);
            end else begin
                if (t_wr[g]) mem[g][t_address[g]] <= t_data_in[g];
                t_data_out[g] <= mem[g][t_address[g]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One APB transfer on instance k; abort_cyc>0 drops sel in that cycle after setup.
    task automatic xfer(input int k, input bit w, input logic [SW-1:0] st,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd, input int abort_cyc);
        bit            e;
        int            idx, exp_lat, exp_wrs, got_lat, wr_cnt, stray;
        logic [DW-1:0] exp_word, exp_rd, got_rd, wr_d;
        logic [IW-1:0] wr_a;
        logic          got_err;

        e        = (a[1:0] != 2'b00) || ((a >> 2) >= AW'(DEPTH));
        idx      = e ? 0 : int'(a >> 2);
        exp_word = ref_mem[k][idx];
        for (int b = 0; b < SW; b++) if (st[b]) exp_word[b*8 +: 8] = wd[b*8 +: 8];
        exp_wrs  = (!e && w && st != '0) ? 1 : 0;
        exp_lat  = ws(k) + ((e || (w && (st == '1 || st == '0))) ? 2 : 3);
        if (w)      exp_rd = exp_hold[k];
        else if (e) exp_rd = '0;
        else        exp_rd = ref_mem[k][idx];

        t_sel[k] = 1'b1; t_enable[k] = 1'b0; t_write[k] = w;
        t_strobe[k] = st; t_addr[k] = a; t_wdata[k] = wd;
        @(posedge clk); #1;
        t_enable[k] = 1'b1;
        t_write[k]  = ~w;
        t_strobe[k] = ~st;
        t_addr[k]   = $urandom;
        t_wdata[k]  = $urandom;
        got_lat = -1; wr_cnt = 0; stray = 0;
        got_err = 1'b0; got_rd = '0; wr_a = '0; wr_d = '0;
        for (int n = 1; n <= 24; n++) begin
            if (n == abort_cyc) begin
                t_sel[k] = 1'b0; t_enable[k] = 1'b0;
            end
            @(negedge clk);
            if (t_wr[k]) begin
                wr_cnt++; wr_a = t_address[k]; wr_d = t_data_in[k];
            end
            if (t_slverr[k] && !t_ready[k]) stray++;
            if (t_ready[k] && got_lat < 0) begin
                got_lat = n; got_err = t_slverr[k]; got_rd = t_rdata[k];
            end
            @(posedge clk); #1;
            if (abort_cyc == 0 && got_lat >= 0) break;
            if (abort_cyc > 0 && n >= abort_cyc + 4) break;
        end
        t_sel[k] = 1'b0; t_enable[k] = 1'b0;

        check($sformatf("slverr_outside_ready k%0d a=%h", k, a), 32'(stray), 0);
        if (abort_cyc > 0) begin
            check($sformatf("abort_ready k%0d", k), 32'(got_lat >= 0), 0);
            check($sformatf("abort_wr k%0d", k), 32'(wr_cnt), 0);
        end else begin
            check($sformatf("latency k%0d w=%0d st=%h a=%h", k, w, st, a), 32'(got_lat), 32'(exp_lat));
            check($sformatf("slverr k%0d a=%h", k, a), 32'(got_err), 32'(e));
            check($sformatf("rdata k%0d w=%0d a=%h", k, w, a), got_rd, exp_rd);
            check($sformatf("wr_pulses k%0d w=%0d st=%h a=%h", k, w, st, a), 32'(wr_cnt), 32'(exp_wrs));
            if (exp_wrs == 1 && wr_cnt == 1) begin
                check($sformatf("wr_address k%0d a=%h", k, a), 32'(wr_a), 32'(idx));
                check($sformatf("wr_data k%0d a=%h", k, a), wr_d, exp_word);
            end
            if (exp_wrs == 1) ref_mem[k][idx] = exp_word;
            if (!w && !e) exp_hold[k] = exp_rd;
        end
    endtask

    initial begin
        int            k, kind, mism;
        logic [AW-1:0] a;
        logic [SW-1:0] st;

        for (int g = 0; g < NI; g++) begin
            t_sel[g] = 1'b0; t_enable[g] = 1'b0; t_write[g] = 1'b0;
            t_strobe[g] = '0; t_addr[g] = '0; t_wdata[g] = '0;
            exp_hold[g] = '0;
            for (int i = 0; i < DEPTH; i++) ref_mem[g][i] = init_word(g, i);
        end
        rst_n = 1'b0; mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("reset_ready k%0d", g), 32'(t_ready[g]), 0);
            check($sformatf("reset_slverr k%0d", g), 32'(t_slverr[g]), 0);
            check($sformatf("reset_rdata k%0d", g), t_rdata[g], 0);
            check($sformatf("reset_wr k%0d", g), 32'(t_wr[g]), 0);
            check($sformatf("reset_address k%0d", g), 32'(t_address[g]), 0);
            check($sformatf("reset_data_in k%0d", g), t_data_in[g], 0);
        end
        mem_init = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        // Full write, read back, partial write, read back (one wait state).
        xfer(1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 0);
        xfer(1, 1'b0, 4'hF, 32'h10, 32'h0, 0);
        xfer(1, 1'b1, 4'b0011, 32'h10, 32'h1122_3344, 0);
        check("mem_word4_after_partial", mem[1][4], 32'hDEAD_3344);
        xfer(1, 1'b0, 4'hF, 32'h10, 32'h0, 0);
        check("rdata_hold_after_read", t_rdata[1], 32'hDEAD_3344);

        // Address errors.
        xfer(1, 1'b1, 4'hF, 32'h12, 32'h0BAD_0BAD, 0);
        xfer(1, 1'b0, 4'hF, 32'(DEPTH * 4), 32'h0, 0);
        xfer(1, 1'b1, 4'hF, 32'h8000_0010, 32'h0BAD_0BAD, 0);
        check("mem_word4_after_errors", mem[1][4], 32'hDEAD_3344);

        // Latency at 0 and 3 wait states, zero-strobe write.
        xfer(0, 1'b0, 4'hF, 32'h08, 32'h0, 0);
        xfer(2, 1'b0, 4'hF, 32'h08, 32'h0, 0);
        xfer(0, 1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF, 0);

        // Back-to-back read then write, then read back.
        xfer(0, 1'b0, 4'hF, 32'h24, 32'h0, 0);
        xfer(0, 1'b1, 4'b1010, 32'h24, 32'hA1B2_C3D4, 0);
        xfer(0, 1'b0, 4'hF, 32'h24, 32'h0, 0);

        // Aborts: sel dropped in ACCESS, and in FETCH of a partial write.
        xfer(2, 1'b1, 4'hF, 32'h40, 32'h1234_5678, 2);
        xfer(2, 1'b0, 4'hF, 32'h40, 32'h0, 0);
        xfer(1, 1'b1, 4'b0101, 32'h44, 32'h5555_AAAA, 3);
        check("mem_after_fetch_abort", mem[1][17], ref_mem[1][17]);
        xfer(1, 1'b0, 4'hF, 32'h44, 32'h0, 0);

        // Reset asserted while a partial write sits in FETCH.
        t_sel[1] = 1'b1; t_enable[1] = 1'b0; t_write[1] = 1'b1;
        t_strobe[1] = 4'b1100; t_addr[1] = 32'h30; t_wdata[1] = 32'hCAFE_F00D;
        @(posedge clk); #1; t_enable[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("fetch_wr_before_reset", 32'(t_wr[1]), 1);
        rst_n = 1'b0;
        #1;
        check("midreset_ready", 32'(t_ready[1]), 0);
        check("midreset_wr", 32'(t_wr[1]), 0);
        check("midreset_address", 32'(t_address[1]), 0);
        check("midreset_data_in", t_data_in[1], 0);
        check("midreset_rdata", t_rdata[1], 0);
        t_sel[1] = 1'b0; t_enable[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int g = 0; g < NI; g++) exp_hold[g] = '0;
        @(posedge clk); #1;
        check("mem_after_midreset", mem[1][12], ref_mem[1][12]);
        xfer(1, 1'b0, 4'hF, 32'h30, 32'h0, 0);

        // Randomised traffic across all instances.
        for (int t = 0; t < 80; t++) begin
            k    = $urandom_range(0, NI - 1);
            kind = $urandom_range(0, 9);
            a    = 32'($urandom_range(0, 15)) << 2;
            if (kind == 0)      a = a | 32'($urandom_range(1, 3));
            else if (kind == 1) a = 32'(DEPTH * 4) + (32'($urandom_range(0, 255)) << 2);
            else if (kind == 2) a = 32'h8000_0000 | a;
            st = SW'($urandom_range(0, 15));
            if (kind >= 7) st = '1;
            xfer(k, 1'($urandom_range(0, 1)), st, a, $urandom, 0);
        end

        mism = 0;
        for (int g = 0; g < NI; g++)
            for (int i = 0; i < DEPTH; i++)
                if (mem[g][i] !== ref_mem[g][i]) mism++;
        check("final_memory_mismatching_words", 32'(mism), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
